// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU control path: bus sources,
// opcodes, the sequencer control-state enum and a timing-state helper.
package cpu_pkg;

    localparam logic [2:0] BUS_ZERO = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [2:0] OP_ALU0  = 3'd0;
    localparam logic [2:0] OP_ALU1  = 3'd1;
    localparam logic [2:0] OP_ALU2  = 3'd2;
    localparam logic [2:0] OP_ALU3  = 3'd3;
    localparam logic [2:0] OP_ALU4  = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd5;
    localparam logic [2:0] OP_ALU6  = 3'd6;
    localparam logic [2:0] OP_HLT   = 3'd7;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_HALTED = 3'd1,
        ST_T0     = 3'd2,
        ST_T1     = 3'd3,
        ST_T2     = 3'd4,
        ST_T3     = 3'd5,
        ST_T4     = 3'd6,
        ST_T5     = 3'd7
    } ctl_state_e;

    // Timing states are laid out contiguously so the T index is an offset.
    function automatic logic [2:0] t_index(input ctl_state_e s);
        logic [2:0] raw;
        raw = s;
        if (s == ST_INIT || s == ST_HALTED) begin
            return 3'd0;
        end
        return raw - 3'd2;
    endfunction

endpackage

// File: rtl/seq_run_ctl.sv
// Run/halt/single-step bookkeeping: mode bit, stop-pending flag and the
// start/step/stop priority, producing go and halt-at-boundary decisions.
module seq_run_ctl
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic step,
    input  logic stop,
    input  logic in_halted,
    input  logic executing,
    input  logic instr_end,
    output logic go,
    output logic halt_at_end
);

    logic single_q, single_d;
    logic pend_q, pend_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            single_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            single_q <= single_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        single_d = single_q;
        pend_d   = pend_q;
        if (in_halted) begin
            pend_d = 1'b0;
            if (step) begin
                single_d = 1'b1;
            end else if (start) begin
                single_d = 1'b0;
            end
        end else if (executing) begin
            // start mid-instruction only matters when stepping: it switches to free-run
            if (start) begin
                single_d = 1'b0;
            end
            if (instr_end) begin
                pend_d = 1'b0;
            end else if (stop) begin
                pend_d = 1'b1;
            end
        end
    end

    assign go          = in_halted & (start | step);
    assign halt_at_end = (single_q & ~start) | pend_q | stop;

endmodule

// File: rtl/cpu_sequencer.sv
// Hardwired control sequencer: fetch/indirect/execute timing states, opcode
// decode and datapath strobes, with run/halt/single-step control.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir,
    input  logic       start,
    input  logic       step,
    input  logic       stop,
    output logic       load_ar,
    output logic       load_pc,
    output logic       inc_pc,
    output logic       clr_pc,
    output logic       load_dr,
    output logic       load_ac,
    output logic       load_ir,
    output logic [2:0] bus_sel,
    output logic [2:0] alu_op,
    output logic       read,
    output logic       write,
    output logic [2:0] t_state,
    output logic       halted,
    output logic       instr_done
);

    ctl_state_e state_q, state_d;
    logic [2:0] op;
    logic       ind;
    logic       instr_end;
    logic       in_halted;
    logic       executing;
    logic       go;
    logic       halt_at_end;
    logic       unused_addr;

    assign op          = ir[6:4];
    assign ind         = ir[7];
    assign unused_addr = ^ir[3:0];
    assign in_halted   = (state_q == ST_HALTED);
    assign executing   = (state_q != ST_INIT) && (state_q != ST_HALTED);
    assign instr_end   = ((state_q == ST_T3) && (op == OP_HLT))
                       || ((state_q == ST_T4) && (op == OP_STORE))
                       || (state_q == ST_T5);

    seq_run_ctl u_run_ctl (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step        (step),
        .stop        (stop),
        .in_halted   (in_halted),
        .executing   (executing),
        .instr_end   (instr_end),
        .go          (go),
        .halt_at_end (halt_at_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_HALTED;
            ST_HALTED: state_d = go ? ST_T0 : ST_HALTED;
            ST_T0:     state_d = ST_T1;
            ST_T1:     state_d = ST_T2;
            ST_T2:     state_d = ST_T3;
            // HLT always parks, independent of run mode
            ST_T3:     state_d = (op == OP_HLT) ? ST_HALTED : ST_T4;
            ST_T4: begin
                if (op == OP_STORE) begin
                    state_d = halt_at_end ? ST_HALTED : ST_T0;
                end else begin
                    state_d = ST_T5;
                end
            end
            ST_T5:     state_d = halt_at_end ? ST_HALTED : ST_T0;
            default:   state_d = ST_INIT;
        endcase
    end

    always_comb begin
        load_ar = 1'b0;
        load_pc = 1'b0;
        inc_pc  = 1'b0;
        clr_pc  = 1'b0;
        load_dr = 1'b0;
        load_ac = 1'b0;
        load_ir = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        halted  = 1'b0;
        bus_sel = BUS_ZERO;
        case (state_q)
            ST_INIT:   clr_pc = 1'b1;
            ST_HALTED: halted = 1'b1;
            ST_T0: begin
                load_ar = 1'b1;
                bus_sel = BUS_PC;
            end
            ST_T1: begin
                read    = 1'b1;
                bus_sel = BUS_MEM;
                load_ir = 1'b1;
                inc_pc  = 1'b1;
            end
            ST_T2: begin
                load_ar = 1'b1;
                bus_sel = BUS_IR;
            end
            ST_T3: begin
                if (ind) begin
                    read    = 1'b1;
                    bus_sel = BUS_MEM;
                    load_ar = 1'b1;
                end
            end
            ST_T4: begin
                if (op == OP_STORE) begin
                    write   = 1'b1;
                    bus_sel = BUS_AC;
                end else begin
                    read    = 1'b1;
                    bus_sel = BUS_MEM;
                    load_dr = 1'b1;
                end
            end
            ST_T5:     load_ac = 1'b1;
            default: ;
        endcase
    end

    assign alu_op     = op;
    assign t_state    = t_index(state_q);
    assign instr_done = instr_end;

endmodule
